p405s_dcu_store_data_buf: RTL

P405S_DCU_STORE_DATA_BUF -- requirements
Module: p405s_dcu_store_data_buf

---
 rtl/p405s_dcu_store_data_buf.sv | 125 ++++++++++++
 1 files changed

// File: rtl/p405s_dcu_store_data_buf.sv
// p405s_dcu_store_data_buf: two-entry store data buffer that aligns core store operands into byte lanes
// Ports:
//    CB, reset_NEG        clock; synchronous active-low reset
//    EXE_*                store operand (inverted), valid, byte offset, size, byte-reverse
//    DCU_flush            discard every buffered store
//    arrWrAccept          downstream consumes the head entry
//    storeHold            buffer full, core must hold its store
//    arrWrValid/Data/ByteEn   head entry towards the array/PLB
//    bypassMuxOut/Valid   youngest entry for the load-side bypass mux
//    alignErr             one-cycle pulse when an accepted store crossed a word boundary
module p405s_dcu_store_data_buf (
   input  logic         CB,
   input  logic         reset_NEG,
   input  logic [0:31]  EXE_dcuData_NEG,
   input  logic         EXE_storeValid,
   input  logic [30:31] EXE_storeAddr,
   input  logic [0:1]   EXE_storeSize,
   input  logic         EXE_byteReverse,
   input  logic         DCU_flush,
   input  logic         arrWrAccept,
   output logic         storeHold,
   output logic         arrWrValid,
   output logic [0:31]  arrWrData,
   output logic [0:3]   arrWrByteEn,
   output logic [0:31]  bypassMuxOut,
   output logic         bypassValid,
   output logic         alignErr
);
   typedef enum logic [1:0] {EMPTY, ONE, FULL} stateT;
   stateT       state, nextState;
   logic [0:31] secData, nHeadData, nSecData, nBypass;
   logic [0:3]  secBe, nHeadBe, nSecBe;
   logic [0:31] operand, revOp, justOp, alignData;
   logic [63:0] rotDbl;
   logic [0:3]  sizeMask, alignBe;
   logic [2:0]  laneCnt;
   logic        push, pop, clip, isByte, isHalf;
   assign storeHold   = state == FULL;
   assign arrWrValid  = state != EMPTY;
   assign bypassValid = state != EMPTY;
   assign push   = EXE_storeValid & ~storeHold & ~DCU_flush;
   assign pop    = arrWrValid & arrWrAccept;
   assign isByte = EXE_storeSize == 2'b00;
   assign isHalf = EXE_storeSize == 2'b01;
   assign operand = ~EXE_dcuData_NEG;
   assign revOp   = (!EXE_byteReverse || isByte) ? operand :
                    isHalf ? {operand[0:15], operand[24:31], operand[16:23]} :
                    {operand[24:31], operand[16:23], operand[8:15], operand[0:7]};
   assign justOp  = isByte ? {revOp[24:31], 24'h0} : isHalf ? {revOp[16:31], 16'h0} : revOp;
   // Rotating the doubled word right by the byte offset puts justified lane (k - addr) mod 4 into lane k.
   assign rotDbl    = {justOp, justOp} >> {EXE_storeAddr, 3'b000};
   assign alignData = rotDbl[31:0];
   assign sizeMask  = isByte ? 4'b1000 : isHalf ? 4'b1100 : 4'b1111;
   assign alignBe   = sizeMask >> EXE_storeAddr;
   assign laneCnt   = isByte ? 3'd1 : isHalf ? 3'd2 : 3'd4;
   assign clip      = ({1'b0, EXE_storeAddr} + laneCnt) > 3'd4;
   always_comb begin
      nextState = state;
      nHeadData = arrWrData;
      nHeadBe   = arrWrByteEn;
      nSecData  = secData;
      nSecBe    = secBe;
      if (DCU_flush) begin
         nextState = EMPTY;
         nHeadData = '0;
         nHeadBe   = '0;
         nSecData  = '0;
         nSecBe    = '0;
      end else begin
         case (state)
            EMPTY: if (push) begin
               nextState = ONE;
               nHeadData = alignData;
               nHeadBe   = alignBe;
            end
            ONE: if (push) begin
               nextState = pop ? ONE : FULL;
               nHeadData = pop ? alignData : arrWrData;
               nHeadBe   = pop ? alignBe : arrWrByteEn;
               nSecData  = pop ? secData : alignData;
               nSecBe    = pop ? secBe : alignBe;
            end else if (pop) begin
               nextState = EMPTY;
               nHeadData = '0;
               nHeadBe   = '0;
            end
            FULL: if (pop) begin
               nextState = ONE;
               nHeadData = secData;
               nHeadBe   = secBe;
               nSecData  = '0;
               nSecBe    = '0;
            end
            default: begin
               nextState = EMPTY;
               nHeadData = '0;
               nHeadBe   = '0;
               nSecData  = '0;
               nSecBe    = '0;
            end
         endcase
      end
      // Empty slots are held at zero, so the tail select needs no extra valid gating.
      nBypass = nextState == FULL ? nSecData : nHeadData;
   end
   always_ff @(posedge CB) begin
      if (!reset_NEG) begin
         state        <= EMPTY;
         arrWrData    <= '0;
         arrWrByteEn  <= '0;
         secData      <= '0;
         secBe        <= '0;
         bypassMuxOut <= '0;
         alignErr     <= 1'b0;
      end else begin
         state        <= nextState;
         arrWrData    <= nHeadData;
         arrWrByteEn  <= nHeadBe;
         secData      <= nSecData;
         secBe        <= nSecBe;
         bypassMuxOut <= nBypass;
         alignErr     <= push & clip;
      end
   end
endmodule
